rtmq_cdc_tx: RTL and testbench

RTMQ_CDC_TX -- requirements
Module: rtmq_cdc_tx

---
 rtl/rtmq_cdc_pkg.sv | 13 +
 rtl/rtmq_sync_bit.sv | 32 +++
 rtl/rtmq_cdc_tx.sv | 102 ++++++++++
 tb/tb_rtmq_cdc_tx.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtmq_cdc_pkg.sv
// Shared definitions for the RTMQ CDC transmit slice: FSM state type and
// synchronizer depth limits.
package rtmq_cdc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } rtmq_cdc_state_t;

  localparam int unsigned N_STG_MIN = 2;
  localparam int unsigned N_STG_MAX = 4;

endpackage

// File: rtl/rtmq_sync_bit.sv
// Single-bit multi-flop synchronizer with async active-low reset.
// Stages are kept as discrete registers (no shift-register extraction) so
// every stage gets full metastability resolution time.
module rtmq_sync_bit
  import rtmq_cdc_pkg::*;
#(
  parameter int unsigned N_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (N_STG < N_STG_MIN || N_STG > N_STG_MAX) begin : g_bad_n_stg
    $error("rtmq_sync_bit: N_STG out of range");
  end

  (* srl_style = "register" *) logic [N_STG-1:0] stg;

  // Plain flop chain, no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else begin
      stg <= {stg[N_STG-2:0], d};
    end
  end

  assign q = stg[N_STG-1];

endmodule

// File: rtl/rtmq_cdc_tx.sv
// Toggle-handshake CDC transmitter. A word is latched into xfr_dat and
// xfr_req is inverted; both are held stable until the synchronized ack
// toggle matches xfr_req, then done pulses and a new word may be taken.
// Optional feature macro: RTMQ_CDC_TX_TMO_EN adds an ack timeout counter
// and the sticky err output.
module rtmq_cdc_tx
  import rtmq_cdc_pkg::*;
#(
  parameter int unsigned W_BUS   = 1,
  parameter int unsigned N_STG   = 2,
  parameter int unsigned TMO_CYC = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_BUS-1:0] inp,
  input  logic             inp_vld,
  output logic             inp_rdy,
  output logic [W_BUS-1:0] xfr_dat,
  output logic             xfr_req,
  input  logic             xfr_ack,
  output logic             done
`ifdef RTMQ_CDC_TX_TMO_EN
  ,
  output logic             err
`endif
);

  if (W_BUS == 0 || W_BUS > 256) begin : g_bad_w_bus
    $error("rtmq_cdc_tx: W_BUS out of range");
  end
  if (TMO_CYC == 0) begin : g_bad_tmo
    $error("rtmq_cdc_tx: TMO_CYC must be nonzero");
  end

  rtmq_cdc_state_t state;
  logic            ack_s;

  rtmq_sync_bit #(
    .N_STG(N_STG)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (xfr_ack),
    .q    (ack_s)
  );

  // Handshake FSM; inp_rdy and done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      inp_rdy <= 1'b1;
      xfr_dat <= '0;
      xfr_req <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (inp_vld) begin
            xfr_dat <= inp;
            xfr_req <= ~xfr_req;
            inp_rdy <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (ack_s == xfr_req) begin
            inp_rdy <= 1'b1;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          inp_rdy <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef RTMQ_CDC_TX_TMO_EN
  localparam int unsigned TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts edges spent in WAIT, saturating at TMO_CYC; err is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_W'(TMO_CYC)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rtmq_cdc_tx.sv
// Self-checking bench for rtmq_cdc_tx (W_BUS=8, N_STG=2).
module tb_rtmq_cdc_tx;

  localparam int unsigned W  = 8;
  localparam int unsigned NS = 2;
`ifdef RTMQ_CDC_TX_TMO_EN
  localparam int unsigned TMO = 15;
`else
  localparam int unsigned TMO = 1023;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] inp;
  logic         inp_vld;
  logic         inp_rdy;
  logic [W-1:0] xfr_dat;
  logic         xfr_req;
  logic         xfr_ack;
  logic         done;
`ifdef RTMQ_CDC_TX_TMO_EN
  logic         err;
`endif

  logic loop;
  logic ack_man;
  assign xfr_ack = loop ? xfr_req : ack_man;

  int checks = 0;
  int errors = 0;

  // Reference model state: a transfer occupies the block for N_STG+1 edges
  // after the accepting edge when ack is looped back.
  bit           m_busy;
  int           m_left;
  logic [W-1:0] m_dat;
  logic         m_req;
  logic         m_done;

  rtmq_cdc_tx #(
    .W_BUS  (W),
    .N_STG  (NS),
    .TMO_CYC(TMO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .inp    (inp),
    .inp_vld(inp_vld),
    .inp_rdy(inp_rdy),
    .xfr_dat(xfr_dat),
    .xfr_req(xfr_req),
    .xfr_ack(xfr_ack),
    .done   (done)
`ifdef RTMQ_CDC_TX_TMO_EN
    ,
    .err    (err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_busy = 0;
    m_left = 0;
    m_dat  = '0;
    m_req  = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic [W-1:0] d);
    if (!m_busy) begin
      m_done = 1'b0;
      if (v) begin
        m_dat  = d;
        m_req  = ~m_req;
        m_busy = 1;
        m_left = NS + 1;
      end
    end else begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0) m_busy = 0;
    end
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    inp_vld = 1'b0;
    inp     = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    inp_vld = 1'b0;
    inp     = '0;
    loop    = 1'b0;
    ack_man = 1'b0;
    tick();
    checks++;
    if ({inp_rdy, xfr_dat, xfr_req, done} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rdy=%b dat=%h req=%b done=%b want rdy=1 dat=00 req=0 done=0",
               inp_rdy, xfr_dat, xfr_req, done);
    end
`ifdef RTMQ_CDC_TX_TMO_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err=%b want 0", err);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int low;
    int dones;
    do_reset();
    loop    = 1'b1;
    inp     = 8'hA5;
    inp_vld = 1'b1;
    tick();
    inp_vld = 1'b0;
    checks++;
    if ({xfr_dat, xfr_req, inp_rdy} !== {8'hA5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_accept: dat=%h req=%b rdy=%b want dat=a5 req=1 rdy=0",
               xfr_dat, xfr_req, inp_rdy);
    end
    low   = 1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!inp_rdy) low++;
      if (done) dones++;
    end
    checks++;
    if (low !== NS + 1) begin
      errors++;
      $display("FAIL single_rdy_low: got %0d cycles want %0d", low, NS + 1);
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL single_done: got %0d pulses want 1", dones);
    end
  endtask

  task automatic test_hold();
    do_reset();
    loop    = 1'b1;
    inp_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      inp = W'($urandom);
      model_step(1'b1, inp);
      tick();
      checks++;
      if ({inp_rdy, xfr_dat, xfr_req, done} !== {!m_busy, m_dat, m_req, m_done}) begin
        errors++;
        $display("FAIL hold[%0d]: rdy=%b dat=%h req=%b done=%b want rdy=%b dat=%h req=%b done=%b",
                 i, inp_rdy, xfr_dat, xfr_req, done, !m_busy, m_dat, m_req, m_done);
      end
    end
    inp_vld = 1'b0;
  endtask

  task automatic test_random();
    logic v;
    do_reset();
    loop = 1'b1;
    for (int i = 0; i < 150; i++) begin
      v       = 1'($urandom_range(0, 1));
      inp_vld = v;
      inp     = W'($urandom);
      model_step(v, inp);
      tick();
      checks++;
      if ({inp_rdy, xfr_dat, xfr_req, done} !== {!m_busy, m_dat, m_req, m_done}) begin
        errors++;
        $display("FAIL random[%0d]: rdy=%b dat=%h req=%b done=%b want rdy=%b dat=%h req=%b done=%b",
                 i, inp_rdy, xfr_dat, xfr_req, done, !m_busy, m_dat, m_req, m_done);
      end
    end
    inp_vld = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[3];
    int           idx;
    int           n;
    int           dones;
    int           toggles;
    logic         prev_req;
    words   = '{8'h01, 8'h02, 8'h03};
    do_reset();
    loop     = 1'b1;
    idx      = 0;
    n        = 0;
    dones    = 0;
    toggles  = 0;
    prev_req = 1'b0;
    inp      = words[0];
    inp_vld  = 1'b1;
    while (dones < 3 && n < 40) begin
      tick();
      n++;
      if (xfr_req !== prev_req) begin
        toggles++;
        checks++;
        if (xfr_dat !== words[idx]) begin
          errors++;
          $display("FAIL b2b_dat[%0d]: dat=%h want %h", idx, xfr_dat, words[idx]);
        end
        prev_req = xfr_req;
        idx++;
        if (idx < 3) inp = words[idx];
        else inp_vld = 1'b0;
      end
      if (done) dones++;
    end
    inp_vld = 1'b0;
    checks++;
    if (n !== 12) begin
      errors++;
      $display("FAIL b2b_cycles: got %0d want 12", n);
    end
    checks++;
    if (toggles !== 3) begin
      errors++;
      $display("FAIL b2b_toggles: got %0d want 3", toggles);
    end
    checks++;
    if (dones !== 3) begin
      errors++;
      $display("FAIL b2b_done: got %0d want 3", dones);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    loop    = 1'b0;
    ack_man = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0) ack_man = ~ack_man;
      tick();
      checks++;
      if ({done, inp_rdy, xfr_req} !== {1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL spurious[%0d]: done=%b rdy=%b req=%b want done=0 rdy=1 req=0",
                 i, done, inp_rdy, xfr_req);
      end
    end
    ack_man = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    loop    = 1'b0;
    ack_man = 1'b0;
    inp     = 8'h3C;
    inp_vld = 1'b1;
    tick();
    inp_vld = 1'b0;
    checks++;
    if ({inp_rdy, xfr_dat, xfr_req} !== {1'b0, 8'h3C, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_wait: rdy=%b dat=%h req=%b want rdy=0 dat=3c req=1",
               inp_rdy, xfr_dat, xfr_req);
    end
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({inp_rdy, xfr_dat, xfr_req, done} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_async: rdy=%b dat=%h req=%b done=%b want rdy=1 dat=00 req=0 done=0",
               inp_rdy, xfr_dat, xfr_req, done);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({done, inp_rdy} !== {1'b0, 1'b1}) begin
        errors++;
        $display("FAIL rstmid_after[%0d]: done=%b rdy=%b want done=0 rdy=1", i, done, inp_rdy);
      end
    end
  endtask

`ifdef RTMQ_CDC_TX_TMO_EN
  task automatic test_timeout();
    int n;
    do_reset();
    loop    = 1'b0;
    ack_man = 1'b0;
    inp     = 8'h5A;
    inp_vld = 1'b1;
    tick();
    inp_vld = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if ({err, inp_rdy} !== {1'(k >= int'(TMO)), 1'b0}) begin
        errors++;
        $display("FAIL tmo[%0d]: err=%b rdy=%b want err=%b rdy=0",
                 k, err, inp_rdy, (k >= int'(TMO)));
      end
    end
    ack_man = 1'b1;
    n = 0;
    while (!done && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if ({done, inp_rdy, err} !== 3'b111) begin
      errors++;
      $display("FAIL tmo_complete: done=%b rdy=%b err=%b want 1 1 1", done, inp_rdy, err);
    end
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: err=%b want 1", err);
    end
  endtask
`endif

  initial begin
    loop    = 1'b0;
    ack_man = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_hold();
    test_random();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
`ifdef RTMQ_CDC_TX_TMO_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
